tff_counter_ctrl: RTL and testbench

Sequencing controller for a WIDTH-bit counter built from toggle flip-flops. It computes the per-bit toggle-enable vector each cycle, so one T-FF bank can run as a binary up, binary down or Gray-code counter. It handles load, a programmed step count, pause/resume/abort and terminal-count/done signalling. It sits between the lab top-level control (buttons/switches) and the T-FF counter datapath.

---
 rtl/tff_ctrl_pkg.sv | 17 +
 rtl/tff_bank.sv | 19 +
 rtl/tff_counter_ctrl.sv | 89 ++++++++
 tb/tb_tff_counter_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/tff_ctrl_pkg.sv
// tff_ctrl_pkg: shared mode encodings, controller states and Gray helpers
package tff_ctrl_pkg;
  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;
  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/tff_bank.sv
// tff_bank: WIDTH independent async-reset toggle flip-flops
module tff_bank #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_tff
    logic r;
    // each bit flips on its own toggle enable
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r <= 1'b0;
      else r <= r ^ t[i];
    end
    assign q[i] = r;
  end
endmodule

// File: rtl/tff_counter_ctrl.sv
// tff_counter_ctrl: sequences a T-FF bank as up/down/Gray counter with load, steps and pause
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] steps,
  input  logic              load_en,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  t_en,
  output logic              busy,
  output logic              done,
  output logic              tc
);
  state_t              state, st_nx;
  logic [1:0]          mode_r;
  logic [STEP_W-1:0]   cnt;
  logic [WIDTH-1:0]    t_up, t_dn, t_gr, t_run, t_nx, q_nx, nb, wrap;
  logic                start_go, run_go, load_go, tc_nx;
  assign start_go = state == ST_IDLE && start && !stop;
  assign run_go   = state == ST_RUN && !stop;
  assign load_go  = state == ST_IDLE && load_en && !start;
  // binary up/down toggle chains: bit i flips when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q[i-1];
      t_dn[i] = t_dn[i-1] & ~q[i-1];
    end
  end
  // Gray step: decode, increment modulo 2^WIDTH in a WIDTH-bit signal, re-encode
  assign nb    = WIDTH'(gray2bin(8'(q))) + WIDTH'(1);
  assign t_gr  = q ^ WIDTH'(bin2gray(8'(nb)));
  assign t_run = mode_r == MODE_UP ? t_up : mode_r == MODE_DOWN ? t_dn :
                 mode_r == MODE_GRAY ? t_gr : '0;
  assign t_nx  = run_go ? t_run : load_go ? q ^ load_val : '0;
  assign t_en  = reset ? '0 : t_nx;
  assign q_nx  = q ^ t_nx;
  assign wrap  = mode_r == MODE_DOWN ? '1 : '0;
  assign tc_nx = run_go && mode_r != MODE_HOLD && q_nx == wrap;
  // next-state selection; stop always takes priority over start
  always_comb begin
    st_nx = state;
    case (state)
      ST_IDLE:  st_nx = start_go ? (steps == '0 ? ST_DONE : ST_RUN) : ST_IDLE;
      ST_RUN:   st_nx = stop ? ST_PAUSE : cnt == STEP_W'(1) ? ST_DONE : ST_RUN;
      ST_PAUSE: st_nx = stop ? ST_IDLE : start ? ST_RUN : ST_PAUSE;
      default:  st_nx = ST_IDLE;
    endcase
  end
  // state, step counter, latched mode and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_r <= MODE_UP;
      busy   <= 1'b0;
      done   <= 1'b0;
      tc     <= 1'b0;
    end else begin
      state <= st_nx;
      busy  <= st_nx == ST_RUN || st_nx == ST_PAUSE;
      done  <= st_nx == ST_DONE;
      tc    <= tc_nx;
      if (start_go) begin
        mode_r <= mode;
        cnt    <= steps;
      end else if (run_go) begin
        cnt <= cnt - STEP_W'(1);
      end
    end
  end
  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .reset (reset),
    .t     (t_en),
    .q     (q)
  );
endmodule

// File: tb/tb_tff_counter_ctrl.sv
// tb_tff_counter_ctrl: table-driven check of the T-FF counter controller
module tb_tff_counter_ctrl;
  typedef struct {
    logic       st, sp;
    logic [1:0] md;
    logic [7:0] stp;
    logic       ld;
    logic [2:0] lv, ten, q;
    logic       b, d, t;
  } vec_t;
  logic       clk = 0, reset = 1, start = 0, stop = 0, load_en = 0;
  logic [1:0] mode = 0;
  logic [7:0] steps = 0;
  logic [2:0] load_val = 0, q, t_en;
  logic       busy, done, tc;
  int         tests = 0, fails = 0;
  vec_t       v[$];
  always #5 clk = ~clk;
  tff_counter_ctrl #(.WIDTH(3), .STEP_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .steps(steps), .load_en(load_en), .load_val(load_val), .q(q),
    .t_en(t_en), .busy(busy), .done(done), .tc(tc)
  );
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic add(input int st, sp, md, stp, ld, lv, ten, eq, b, d, t);
    vec_t r;
    r.st = 1'(st); r.sp = 1'(sp); r.md = 2'(md); r.stp = 8'(stp);
    r.ld = 1'(ld); r.lv = 3'(lv); r.ten = 3'(ten); r.q = 3'(eq);
    r.b = 1'(b); r.d = 1'(d); r.t = 1'(t);
    v.push_back(r);
  endtask
  task automatic idle_row(input int ten, eq, b, d, t);
    add(0, 0, 0, 0, 0, 0, ten, eq, b, d, t);
  endtask
  initial begin
    #2;
    chk("reset q", 8'(q), 0);
    chk("reset t_en", 8'(t_en), 0);
    chk("reset flags", {5'b0, busy, done, tc}, 0);
    // up count 10 steps, DONE ignores start/load
    add(1, 0, 0, 10, 0, 0, 0, 0, 1, 0, 0);
    idle_row(1, 1, 1, 0, 0); idle_row(3, 2, 1, 0, 0); idle_row(1, 3, 1, 0, 0);
    idle_row(7, 4, 1, 0, 0); idle_row(1, 5, 1, 0, 0); idle_row(3, 6, 1, 0, 0);
    idle_row(1, 7, 1, 0, 0); idle_row(7, 0, 1, 0, 1); idle_row(1, 1, 1, 0, 0);
    idle_row(3, 2, 0, 1, 0);
    add(1, 0, 0, 5, 1, 5, 0, 2, 0, 0, 0);
    // loads then down count 3 from 2
    add(0, 0, 0, 0, 1, 5, 7, 5, 0, 0, 0);
    add(0, 0, 0, 0, 1, 2, 7, 2, 0, 0, 0);
    add(1, 0, 1, 3, 0, 0, 0, 2, 1, 0, 0);
    idle_row(3, 1, 1, 0, 0); idle_row(1, 0, 1, 0, 0); idle_row(7, 7, 0, 1, 1);
    idle_row(0, 7, 0, 0, 0);
    // load 0 (no tc on load), Gray 8 steps
    add(0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0);
    add(1, 0, 2, 8, 0, 0, 0, 0, 1, 0, 0);
    idle_row(1, 1, 1, 0, 0); idle_row(2, 3, 1, 0, 0); idle_row(1, 2, 1, 0, 0);
    idle_row(4, 6, 1, 0, 0); idle_row(1, 7, 1, 0, 0); idle_row(2, 5, 1, 0, 0);
    idle_row(1, 4, 1, 0, 0); idle_row(4, 0, 0, 1, 1); idle_row(0, 0, 0, 0, 0);
    // pause and resume; mode input changes ignored while busy
    add(1, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0);
    idle_row(1, 1, 1, 0, 0); idle_row(3, 2, 1, 0, 0); idle_row(1, 3, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 7, 4, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 5, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3, 6, 0, 1, 0);
    idle_row(0, 6, 0, 0, 0);
    // pause then abort
    add(0, 0, 0, 0, 1, 0, 6, 0, 0, 0, 0);
    add(1, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0);
    idle_row(1, 1, 1, 0, 0); idle_row(3, 2, 1, 0, 0); idle_row(1, 3, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    idle_row(0, 3, 0, 0, 0);
    // steps=0, start+stop in IDLE, start+load
    add(1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    idle_row(0, 3, 0, 0, 0);
    add(1, 1, 0, 5, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 2, 1, 0, 0, 0);
    add(1, 0, 0, 2, 1, 6, 0, 1, 1, 0, 0);
    idle_row(3, 2, 1, 0, 0); idle_row(1, 3, 0, 1, 0); idle_row(0, 3, 0, 0, 0);
    // reserved mode holds q but consumes steps
    add(1, 0, 3, 2, 0, 0, 0, 3, 1, 0, 0);
    idle_row(0, 3, 1, 0, 0); idle_row(0, 3, 0, 1, 0); idle_row(0, 3, 0, 0, 0);
    // start+stop in RUN pauses, then abort
    add(1, 0, 0, 3, 0, 0, 0, 3, 1, 0, 0);
    idle_row(7, 4, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    @(negedge clk) reset = 0;
    for (int i = 0; i < v.size(); i++) begin
      start = v[i].st; stop = v[i].sp; mode = v[i].md; steps = v[i].stp;
      load_en = v[i].ld; load_val = v[i].lv;
      #1 chk($sformatf("row%0d t_en", i), 8'(t_en), 8'(v[i].ten));
      @(posedge clk); #1;
      chk($sformatf("row%0d q", i), 8'(q), 8'(v[i].q));
      chk($sformatf("row%0d busy/done/tc", i), {5'b0, busy, done, tc},
          {5'b0, v[i].b, v[i].d, v[i].t});
      @(negedge clk);
    end
    // async reset mid-run at q=5
    start = 1; stop = 0; mode = 0; steps = 10; load_en = 0;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1 chk("pre-reset q", 8'(q), 5);
    #2 reset = 1; load_en = 1; load_val = 7;
    #1 chk("async reset q", 8'(q), 0);
    chk("async reset flags", {5'b0, busy, done, tc}, 0);
    chk("t_en in reset", 8'(t_en), 0);
    @(negedge clk) reset = 0; load_en = 0;
    @(posedge clk); #1 chk("after reset q", 8'(q), 0);
    chk("after reset busy", {7'b0, busy}, 0);
    load_en = 1; load_val = 6;
    #1 chk("idle after reset t_en", 8'(t_en), 6);
    @(posedge clk); #1 chk("idle after reset load", 8'(q), 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
